bkm_iter_ctrl: RTL
==================

// Module: bkm_iter_ctrl
// PURPOSE
//  Iteration sequencer that runs the bkm_step datapath N times per operation.
//  Sits directly upstream of bkm_step:
//   - latches the initial operands via a valid/ready handshake;
//   - drives n, d_x_n, d_y_n, X_n, Y_n, u_n, v_n each iteration;
//   - captures X_np1, Y_np1, u_np1, v_np1 back into its state registers;
//   - returns the final values via a valid/ready handshake.
// PARAMETERS
//  W         8  datapath word width (binary); CSD vectors are 2*W bits.
//  LOG2W     3  log2(W).
//  N         8  iterations per operation; 2 <= N <= 2**LOG2N.
//  LOG2N     3  iteration counter width.
//  STEP_LAT  1  bkm_step latency in cycles (X_np1 valid STEP_LAT cycles after issue); 1..3.
//  THR       16 digit-selection threshold, two's complement; default 2**(W-4).
// PORTS
//  clk          in   1       clock.
//  srst         in   1       synchronous active-high reset.
//  enable       in   1       clock enable; low freezes all state and outputs.
//  in_valid     in   1       operand request.
//  in_ready     out  1       high only in IDLE.
//  in_mode      in   1       0 = E-mode, 1 = L-mode; latched at accept.
//  in_format    in   2       passed to bkm_step unchanged; latched at accept.
//  in_X, in_Y   in   2*W     initial X_0, Y_0 (CSD).
//  in_u, in_v   in   W       initial u_0, v_0 (two's complement).
//  st_mode      out  1       to bkm_step mode.
//  st_format    out  2       to bkm_step format.
//  st_n         out  LOG2N   to bkm_step n; also the LUT address.
//  st_d_x       out  2       to bkm_step d_x_n.
//  st_d_y       out  2       to bkm_step d_y_n.
//  st_X, st_Y   out  2*W     to bkm_step X_n, Y_n.
//  st_u, st_v   out  W       to bkm_step u_n, v_n.
//  st_issue     out  1       one-cycle strobe: st_* operands are valid this cycle.
//  nx_X, nx_Y   in   2*W     from bkm_step X_np1, Y_np1.
//  nx_u, nx_v   in   W       from bkm_step u_np1, v_np1.
//  out_valid    out  1       result available.
//  out_ready    in   1       result consumer ready.
//  out_X, out_Y out  2*W     final X_N, Y_N.
//  out_u, out_v out  W       final u_N, v_N.
// BEHAVIOUR
//  Reset (srst=1 at a clk edge, regardless of enable):
//   - FSM goes to IDLE; cnt = 0;
//   - st_*, out_* and all state registers are cleared to 0;
//   - in_ready = 1, out_valid = 0, st_issue = 0.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//  All transitions qualify on enable=1.
//   - IDLE: in_valid & in_ready loads the regs from in_* and sets cnt=0 -> ISSUE.
//   - ISSUE: st_issue=1 for one cycle; st_n=cnt; digits from bkm_dsel -> WAIT with wcnt=STEP_LAT-1.
//   - WAIT: st_* held stable; when wcnt==0, capture nx_* into the regs.
//     * cnt==N-1 -> DONE, copy the regs to out_*, out_valid=1.
//     * otherwise cnt+=1 -> ISSUE.
//   - DONE: out_* held until out_valid & out_ready -> IDLE, out_valid=0.
//  in_ready and out_valid are never high together. A new operand is accepted
//  no earlier than the cycle after the out handshake.
//  Latency: accept edge to out_valid = N*(1+STEP_LAT)+1 cycles (17 at the defaults).
//  st_* outputs are registered and remain stable from ISSUE through WAIT.
//  Digit code (d_x, d_y): 2'b00 = 0, 2'b01 = +1, 2'b11 = -1; 2'b10 is never driven.
//  Selection residual r:
//   - E-mode: r = u for d_x, r = v for d_y.
//   - L-mode: r = W-bit binary of X (for d_x) or Y (for d_y), converted via csd2bin.
//  Selection rule: d = +1 if r >= THR; d = -1 if r < -THR; else d = 0.
//  Comparisons are signed, W bits.
//  Iteration counter: cnt never wraps; the N-1 check comes before the increment.
//  srst mid-operation aborts the operation with no result; the next in_valid
//  is accepted from IDLE.
//  enable=0 during WAIT also freezes wcnt. The bench therefore keeps
//  bkm_step.enable equal to this enable.
// STRUCTURE
//  Shared package bkm_pkg:
//   - digit codes D_ZERO, D_POS, D_NEG;
//   - state encodings S_IDLE, S_ISSUE, S_WAIT, S_DONE.
//  One sub-module, bkm_dsel (combinational):
//   - inputs: mode, X, Y, u, v;
//   - outputs: d_x, d_y;
//   - instantiates two csd2bin for the L-mode path.
//  The FSM, the counters and the registers stay in bkm_iter_ctrl.
// TESTING
//  1. srst held 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, st_issue=0, all outputs 0.
//  2. E-mode, u=v=0, nx_* looped from a bkm_step model -> d=00 every iteration;
//     st_n steps 0..7; out_valid exactly 17 cycles after accept.
//  3. E-mode: u=16 -> d_x=01; u=15 -> d_x=00; v=-17 -> d_y=11; v=-16 -> d_y=00 (THR boundary).
//  4. out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0;
//     in_valid during DONE is not accepted until the cycle after the handshake.
//  5. enable=0 for 4 cycles inside WAIT -> total latency 21; captured values unchanged.
//  6. srst at iteration 3 -> IDLE next cycle, no out_valid;
//     back-to-back operation then completes with the correct st_n sequence from 0.

Source files
------------

// File: rtl/bkm_pkg.sv
// Shared types for the BKM iteration sequencer: signed-digit codes, FSM states
// and the width of the step-latency counter.
package bkm_pkg;

   typedef logic [1:0] digit_t;

   localparam digit_t D_ZERO = 2'b00;
   localparam digit_t D_POS  = 2'b01;
   localparam digit_t D_NEG  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Wide enough for a step latency of up to 3 cycles.
   localparam int WCNT_W = 2;

endpackage

// File: rtl/bkm_dsel.sv
// Digit selection for one BKM iteration: picks d_x/d_y in {-1, 0, +1} by
// comparing a signed residual against +/-THR.
module bkm_dsel
   import bkm_pkg::*;
#(
   parameter int W   = 8,
   parameter int THR = 16
) (
   input  logic           mode,
   input  logic [2*W-1:0] x,
   input  logic [2*W-1:0] y,
   input  logic [W-1:0]   u,
   input  logic [W-1:0]   v,
   output digit_t         d_x,
   output digit_t         d_y
);

   localparam logic signed [W-1:0] THR_POS = W'(THR);
   localparam logic signed [W-1:0] THR_NEG = W'(-THR);

   logic [W-1:0]        x_bin;
   logic [W-1:0]        y_bin;
   logic signed [W-1:0] r_x;
   logic signed [W-1:0] r_y;

   csd2bin #(.W(W)) u_x2b (.csd(x), .bin(x_bin));
   csd2bin #(.W(W)) u_y2b (.csd(y), .bin(y_bin));

   function automatic digit_t sel(input logic signed [W-1:0] r);
      if (r >= THR_POS)     return D_POS;
      else if (r < THR_NEG) return D_NEG;
      else                  return D_ZERO;
   endfunction

   // L-mode steers on the rotating vector itself, E-mode on the residuals.
   always_comb begin
      r_x = mode ? x_bin : u;
      r_y = mode ? y_bin : v;
      d_x = sel(r_x);
      d_y = sel(r_y);
   end

endmodule

// File: rtl/csd2bin.sv
// Converts a W-digit signed-digit vector (2 bits per digit, LSD first) to a
// W-bit two's complement value; the result wraps modulo 2**W.
module csd2bin
   import bkm_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [2*W-1:0] csd,
   output logic [W-1:0]   bin
);

   logic [W-1:0] pos_bits;
   logic [W-1:0] neg_bits;

   always_comb begin
      pos_bits = '0;
      neg_bits = '0;
      for (int i = 0; i < W; i++) begin
         pos_bits[i] = (csd[2*i +: 2] == D_POS);
         neg_bits[i] = (csd[2*i +: 2] == D_NEG);
      end
      bin = pos_bits - neg_bits;
   end

endmodule

// File: rtl/bkm_iter_ctrl.sv
// Sequences N passes of the bkm_step datapath per operation, with operand
// accept and result return over valid/ready handshakes.
//
//  state   | meaning
//  S_IDLE  | in_ready high, waiting for operands
//  S_ISSUE | st_issue high, st_* operands presented to bkm_step
//  S_WAIT  | st_* held, counting down the step latency, then capture nx_*
//  S_DONE  | result on out_*, waiting for out_ready
module bkm_iter_ctrl
   import bkm_pkg::*;
#(
   parameter int W        = 8,
   parameter int LOG2W    = 3,
   parameter int N        = 8,
   parameter int LOG2N    = 3,
   parameter int STEP_LAT = 1,
   parameter int THR      = 2**(W-4)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [1:0]       in_format,
   input  logic [2*W-1:0]   in_X,
   input  logic [2*W-1:0]   in_Y,
   input  logic [W-1:0]     in_u,
   input  logic [W-1:0]     in_v,
   output logic             st_mode,
   output logic [1:0]       st_format,
   output logic [LOG2N-1:0] st_n,
   output logic [1:0]       st_d_x,
   output logic [1:0]       st_d_y,
   output logic [2*W-1:0]   st_X,
   output logic [2*W-1:0]   st_Y,
   output logic [W-1:0]     st_u,
   output logic [W-1:0]     st_v,
   output logic             st_issue,
   input  logic [2*W-1:0]   nx_X,
   input  logic [2*W-1:0]   nx_Y,
   input  logic [W-1:0]     nx_u,
   input  logic [W-1:0]     nx_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_X,
   output logic [2*W-1:0]   out_Y,
   output logic [W-1:0]     out_u,
   output logic [W-1:0]     out_v
);

   if (2**LOG2W != W || N < 2 || N > 2**LOG2N || STEP_LAT < 1 || STEP_LAT > 3)
   begin : g_bad_param
      $error("bkm_iter_ctrl: illegal parameter set");
   end

   state_t              state_q, state_d;
   logic [LOG2N-1:0]    cnt_q, cnt_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                mode_q, mode_d;
   logic [1:0]          fmt_q, fmt_d;
   logic [2*W-1:0]      x_q, x_d, y_q, y_d;
   logic [W-1:0]        u_q, u_d, v_q, v_d;
   digit_t              dx_q, dx_d, dy_q, dy_d;
   logic                out_valid_q, out_valid_d;
   logic [2*W-1:0]      out_x_q, out_x_d, out_y_q, out_y_d;
   logic [W-1:0]        out_u_q, out_u_d, out_v_q, out_v_d;

   logic                last_iter;
   logic                sel_mode;
   logic [2*W-1:0]      sel_x, sel_y;
   logic [W-1:0]        sel_u, sel_v;
   digit_t              sel_dx, sel_dy;

   assign last_iter = (cnt_q == LOG2N'(N-1));

   // Digits are chosen from the values about to be loaded, so the operand
   // registers and their digits update on the same edge.
   always_comb begin
      sel_mode = (state_q == S_IDLE) ? in_mode : mode_q;
      sel_x    = (state_q == S_IDLE) ? in_X    : nx_X;
      sel_y    = (state_q == S_IDLE) ? in_Y    : nx_Y;
      sel_u    = (state_q == S_IDLE) ? in_u    : nx_u;
      sel_v    = (state_q == S_IDLE) ? in_v    : nx_v;
   end

   bkm_dsel #(.W(W), .THR(THR)) u_dsel (
      .mode (sel_mode),
      .x    (sel_x),
      .y    (sel_y),
      .u    (sel_u),
      .v    (sel_v),
      .d_x  (sel_dx),
      .d_y  (sel_dy)
   );

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         mode_q      <= 1'b0;
         fmt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         u_q         <= '0;
         v_q         <= '0;
         dx_q        <= D_ZERO;
         dy_q        <= D_ZERO;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_u_q     <= '0;
         out_v_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         mode_q      <= mode_d;
         fmt_q       <= fmt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         u_q         <= u_d;
         v_q         <= v_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_u_q     <= out_u_d;
         out_v_q     <= out_v_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wcnt_q == '0) state_d = last_iter ? S_DONE : S_ISSUE;
            S_DONE:  if (out_valid_q && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      wcnt_d      = wcnt_q;
      mode_d      = mode_q;
      fmt_d       = fmt_q;
      x_d         = x_q;
      y_d         = y_q;
      u_d         = u_q;
      v_d         = v_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_u_d     = out_u_q;
      out_v_d     = out_v_q;
      if (enable) begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               mode_d = in_mode;
               fmt_d  = in_format;
               x_d    = in_X;
               y_d    = in_Y;
               u_d    = in_u;
               v_d    = in_v;
               dx_d   = sel_dx;
               dy_d   = sel_dy;
               cnt_d  = '0;
            end
            S_ISSUE: wcnt_d = WCNT_W'(STEP_LAT - 1);
            S_WAIT: if (wcnt_q == '0) begin
               x_d = nx_X;
               y_d = nx_Y;
               u_d = nx_u;
               v_d = nx_v;
               if (!last_iter) begin
                  cnt_d = cnt_q + LOG2N'(1);
                  dx_d  = sel_dx;
                  dy_d  = sel_dy;
               end
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
            S_DONE: if (!out_valid_q) begin
               out_x_d     = x_q;
               out_y_d     = y_q;
               out_u_d     = u_q;
               out_v_d     = v_q;
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      st_issue  = (state_q == S_ISSUE);
      st_mode   = mode_q;
      st_format = fmt_q;
      st_n      = cnt_q;
      st_d_x    = dx_q;
      st_d_y    = dy_q;
      st_X      = x_q;
      st_Y      = y_q;
      st_u      = u_q;
      st_v      = v_q;
      out_valid = out_valid_q;
      out_X     = out_x_q;
      out_Y     = out_y_q;
      out_u     = out_u_q;
      out_v     = out_v_q;
   end

endmodule
